// File: rtl/rf_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_access_pkg
// Brief    : Shared types, sizes and the byte-merge helper for rf_access_ctrl.
//            Optional same-cycle bypass is enabled by RF_ACCESS_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
package rf_access_pkg;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int BYTES = 8;
    localparam int WIDTH = 64;

    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0] base,
        input logic [WIDTH-1:0] ovr,
        input logic [BYTES-1:0] be
    );
        logic [WIDTH-1:0] res;
        res = base;
        for (int i = 0; i < BYTES; i++) begin
            if (be[i]) res[i*8 +: 8] = ovr[i*8 +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_bypass_merge.sv
`default_nettype none
// ============================================================================
// Module   : rf_bypass_merge
// Brief    : Per-byte overlay of captured write bytes onto macro read data.
// Revision : 1.0 - initial release
// ============================================================================
module rf_bypass_merge
    import rf_access_pkg::*;
(
    input  logic [WIDTH-1:0] i_ram_do1,
    input  logic [WIDTH-1:0] i_byp_data,
    input  logic [BYTES-1:0] i_byp_be,
    output logic [WIDTH-1:0] o_rsp_data
);

    assign o_rsp_data = merge_bytes(i_ram_do1, i_byp_data, i_byp_be);

endmodule
`default_nettype wire

// File: rtl/rf_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rf_access_ctrl
// Brief    : Write/read arbitration, zero-init and read coherency in front of
//            a 2**BITS x 64 register-file macro. Macro: RF_ACCESS_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rf_access_ctrl
    import rf_access_pkg::*;
#(
    parameter int BITS = 5
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clr,
    output logic             busy,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [BITS-1:0]  wr_addr,
    input  logic [BYTES-1:0] wr_be,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [BITS-1:0]  rd_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             ram_en0,
    output logic [BITS-1:0]  ram_a0,
    output logic [BYTES-1:0] ram_we0,
    output logic [WIDTH-1:0] ram_di0,
    output logic             ram_en1,
    output logic [BITS-1:0]  ram_a1,
    input  logic [WIDTH-1:0] ram_do1
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BITS-1:0] r_init_cnt;
    logic [BITS-1:0] w_init_cnt_nxt;
    logic            r_clr_pend;
    logic            w_clr_pend_nxt;
    logic            r_rsp_valid;
    logic            w_rsp_valid_nxt;
    logic            w_run;
    logic            w_wr_acc;
    logic            w_rd_acc;
    logic            w_rd_free;

    assign w_run     = (r_state == S_RUN);
    assign wr_ready  = w_run & ~r_clr_pend;
    assign w_wr_acc  = wr_valid & wr_ready;
    assign rd_ready  = w_run & ~r_clr_pend & (~r_rsp_valid | rsp_ready) & w_rd_free;
    assign w_rd_acc  = rd_valid & rd_ready;
    assign rsp_valid = r_rsp_valid;

`ifdef RF_ACCESS_BYPASS_EN
    logic [BYTES-1:0] r_byp_be;
    logic [WIDTH-1:0] r_byp_data;

    assign w_rd_free = 1'b1;

    // Capture colliding write bytes at read accept so the response is a snapshot
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_byp_be   <= '0;
            r_byp_data <= '0;
        end else if (w_rd_acc) begin
            r_byp_be   <= (w_wr_acc && (wr_addr == rd_addr)) ? wr_be : '0;
            r_byp_data <= wr_data;
        end
    end

    rf_bypass_merge u_merge (
        .i_ram_do1  (ram_do1),
        .i_byp_data (r_byp_data),
        .i_byp_be   (r_byp_be),
        .o_rsp_data (rsp_data)
    );
`else
    // Without merge logic a same-entry read must wait for the write to land
    assign w_rd_free = ~(w_wr_acc & (wr_addr == rd_addr));
    assign rsp_data  = ram_do1;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_INIT;
            r_init_cnt  <= '0;
            r_clr_pend  <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_cnt  <= w_init_cnt_nxt;
            r_clr_pend  <= w_clr_pend_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_init_cnt_nxt  = r_init_cnt;
        w_clr_pend_nxt  = r_clr_pend;
        w_rsp_valid_nxt = w_rd_acc ? 1'b1 : (rsp_ready ? 1'b0 : r_rsp_valid);
        case (r_state)
            S_INIT: begin
                w_init_cnt_nxt = r_init_cnt + 1'b1;
                if (&r_init_cnt) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                // A pending response drains before the array is re-zeroed
                if (r_clr_pend && !r_rsp_valid) begin
                    w_state_nxt    = S_INIT;
                    w_init_cnt_nxt = '0;
                    w_clr_pend_nxt = 1'b0;
                end else if (clr) begin
                    w_clr_pend_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    // Port 0 stays quiet while reset is held even though the state reads INIT
    always_comb begin
        busy    = ~w_run;
        ram_en0 = 1'b0;
        ram_a0  = wr_addr;
        ram_we0 = '0;
        ram_di0 = wr_data;
        ram_en1 = 1'b0;
        ram_a1  = rd_addr;
        if (!w_run) begin
            ram_en0 = RST_N;
            ram_a0  = r_init_cnt;
            ram_we0 = {BYTES{RST_N}};
            ram_di0 = '0;
        end else begin
            ram_en0 = w_wr_acc;
            ram_we0 = w_wr_acc ? wr_be : '0;
            ram_en1 = w_rd_acc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_access_ctrl
// Brief    : Self-checking bench for rf_access_ctrl with a macro model and an
//            array-level reference model. Honours RF_ACCESS_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_access_ctrl;

    localparam int BITS = 5;
    localparam int N    = 2**BITS;
`ifdef RF_ACCESS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RST_N;
    logic            clr;
    logic            busy;
    logic            wr_valid;
    logic            wr_ready;
    logic [BITS-1:0] wr_addr;
    logic [7:0]      wr_be;
    logic [63:0]     wr_data;
    logic            rd_valid;
    logic            rd_ready;
    logic [BITS-1:0] rd_addr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [63:0]     rsp_data;
    logic            ram_en0;
    logic [BITS-1:0] ram_a0;
    logic [7:0]      ram_we0;
    logic [63:0]     ram_di0;
    logic            ram_en1;
    logic [BITS-1:0] ram_a1;
    logic [63:0]     ram_do1;

    rf_access_ctrl #(.BITS(BITS)) dut (
        .CLK(CLK), .RST_N(RST_N), .clr(clr), .busy(busy),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_be(wr_be), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_en0(ram_en0), .ram_a0(ram_a0), .ram_we0(ram_we0), .ram_di0(ram_di0),
        .ram_en1(ram_en1), .ram_a1(ram_a1), .ram_do1(ram_do1)
    );

    always #5 CLK = ~CLK;

    // Register-file macro: byte-write port 0, registered read port 1
    logic [63:0] mem [N];
    logic [63:0] t_word;
    always @(posedge CLK) begin
        if (ram_en0) begin
            t_word = mem[ram_a0];
            for (int b = 0; b < 8; b++) if (ram_we0[b]) t_word[b*8 +: 8] = ram_di0[b*8 +: 8];
            mem[ram_a0] <= t_word;
        end
        if (ram_en1) ram_do1 <= mem[ram_a1];
    end

    // Reference model: expected array contents and pending response
    logic [63:0]     ref_mem [N];
    int              m_init_left;
    logic [BITS-1:0] m_init_addr;
    bit              m_clr_pend;
    bit              m_rsp_pend;
    logic [63:0]     m_rsp_val;
    bit              last_racc;

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit wv, input int wa, input logic [7:0] wbe, input logic [63:0] wd,
                         input bit rv, input int ra, input bit rr, input bit c);
        wr_valid  = wv;
        wr_addr   = BITS'(wa);
        wr_be     = wbe;
        wr_data   = wd;
        rd_valid  = rv;
        rd_addr   = BITS'(ra);
        rsp_ready = rr;
        clr       = c;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge
    task automatic step();
        bit busy_e, wr_rdy_e, rd_rdy_e, wacc, racc, pend_old;
        @(negedge CLK);
        busy_e = (m_init_left > 0);
        chk("busy", 64'(busy), 64'(busy_e));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_pend));
        if (m_rsp_pend) chk("rsp_data", rsp_data, m_rsp_val);
        if (busy_e) begin
            wr_rdy_e = 1'b0;
            rd_rdy_e = 1'b0;
            chk("init_en0", 64'(ram_en0), 64'(1));
            chk("init_we0", 64'(ram_we0), 64'(8'hFF));
            chk("init_a0", 64'(ram_a0), 64'(m_init_addr));
            chk("init_di0", ram_di0, 64'h0);
        end else begin
            wr_rdy_e = !m_clr_pend;
            rd_rdy_e = !m_clr_pend && (!m_rsp_pend || rsp_ready)
                       && (BYP || !(wr_valid && wr_rdy_e && wr_addr == rd_addr));
        end
        chk("wr_ready", 64'(wr_ready), 64'(wr_rdy_e));
        chk("rd_ready", 64'(rd_ready), 64'(rd_rdy_e));
        wacc = wr_valid && wr_rdy_e;
        racc = rd_valid && rd_rdy_e;
        if (!busy_e) chk("en0", 64'(ram_en0), 64'(wacc));
        if (wacc) begin
            chk("a0", 64'(ram_a0), 64'(wr_addr));
            chk("we0", 64'(ram_we0), 64'(wr_be));
            chk("di0", ram_di0, wr_data);
        end
        chk("en1", 64'(ram_en1), 64'(racc));
        if (racc) chk("a1", 64'(ram_a1), 64'(rd_addr));
        @(posedge CLK);
        if (busy_e) begin
            ref_mem[m_init_addr] = 64'h0;
            m_init_addr++;
            m_init_left--;
        end else begin
            if (wacc)
                for (int b = 0; b < 8; b++)
                    if (wr_be[b]) ref_mem[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
            pend_old = m_rsp_pend;
            if (racc) begin
                m_rsp_val  = ref_mem[rd_addr];
                m_rsp_pend = 1'b1;
            end else if (rsp_ready) begin
                m_rsp_pend = 1'b0;
            end
            if (m_clr_pend && !pend_old) begin
                m_init_left = N;
                m_init_addr = '0;
                m_clr_pend  = 1'b0;
            end else if (clr) begin
                m_clr_pend = 1'b1;
            end
        end
        last_racc = racc;
        #1;
    endtask

    task automatic do_reset(input int hold);
        drive(0, 0, 8'h00, 64'h0, 0, 0, 1, 0);
        RST_N = 1'b0;
        #2;
        chk("rst_busy", 64'(busy), 64'(1));
        chk("rst_wr_ready", 64'(wr_ready), 64'(0));
        chk("rst_rd_ready", 64'(rd_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_en0", 64'(ram_en0), 64'(0));
        chk("rst_en1", 64'(ram_en1), 64'(0));
        chk("rst_we0", 64'(ram_we0), 64'(0));
        repeat (hold) @(posedge CLK);
        #1;
        RST_N       = 1'b1;
        m_init_left = N;
        m_init_addr = '0;
        m_clr_pend  = 1'b0;
        m_rsp_pend  = 1'b0;
    endtask

    initial begin
        int icnt;
        RST_N = 1'b0;
        drive(0, 0, 8'h00, 64'h0, 0, 0, 1, 0);
        do_reset(2);

        // Reset in the middle of INIT restarts the sweep from entry 0
        repeat (10) step();
        chk("init_cnt_10", 64'(ram_a0), 64'(10));
        do_reset(1);
        chk("init_restart_a0", 64'(ram_a0), 64'(0));
        repeat (N) step();
        chk("init_done", 64'(busy), 64'(0));

        // Freshly initialised entry reads zero
        drive(0, 0, 8'h00, 64'h0, 1, 7, 1, 0); step();
        chk("rd7_valid", 64'(rsp_valid), 64'(1));
        chk("rd7_data", rsp_data, 64'h0);
        drive(0, 0, 8'h00, 64'h0, 0, 0, 1, 0); step();

        // Write then read next cycle
        drive(1, 3, 8'hFF, 64'h0123456789ABCDEF, 0, 0, 1, 0); step();
        drive(0, 0, 8'h00, 64'h0, 1, 3, 1, 0); step();
        chk("rd3_data", rsp_data, 64'h0123456789ABCDEF);
        drive(0, 0, 8'h00, 64'h0, 0, 0, 1, 0); step();

        // Same-cycle partial write and read of entry 5
        drive(1, 5, 8'hFF, 64'h1111111122222222, 0, 0, 1, 0); step();
        drive(1, 5, 8'h0F, 64'hFFFFFFFF_AAAAAAAA, 1, 5, 1, 0); step();
        chk("coll_acc", 64'(last_racc), 64'(BYP));
        for (int t = 0; t < 4 && !last_racc; t++) begin
            drive(0, 0, 8'h00, 64'h0, 1, 5, 1, 0); step();
        end
        chk("coll_data", rsp_data, 64'h11111111AAAAAAAA);
        drive(0, 0, 8'h00, 64'h0, 0, 0, 1, 0); step();

        // Stalled response is a snapshot; entry 3 rewritten underneath
        drive(0, 0, 8'h00, 64'h0, 1, 3, 0, 0); step();
        for (int t = 0; t < 4; t++) begin
            drive(1, 3, 8'hFF, 64'h5555666677778888, 1, 3, 0, 0); step();
            chk("hold_data", rsp_data, 64'h0123456789ABCDEF);
        end
        drive(0, 0, 8'h00, 64'h0, 0, 0, 1, 0); step();
        drive(0, 0, 8'h00, 64'h0, 1, 3, 1, 0); step();
        chk("rewr_data", rsp_data, 64'h5555666677778888);
        drive(0, 0, 8'h00, 64'h0, 0, 0, 1, 0); step();

        // clr with a response pending: drain first, then a full INIT
        drive(0, 0, 8'h00, 64'h0, 1, 3, 0, 0); step();
        drive(0, 0, 8'h00, 64'h0, 0, 0, 0, 1); step();
        drive(0, 0, 8'h00, 64'h0, 0, 0, 0, 0); step(); step();
        drive(0, 0, 8'h00, 64'h0, 0, 0, 1, 0); step();
        chk("clr_not_yet", 64'(busy), 64'(0));
        step();
        icnt = 0;
        for (int t = 0; t < N + 8; t++) begin
            if (!busy) break;
            icnt++;
            step();
        end
        chk("clr_init_len", 64'(icnt), 64'(N));
        drive(0, 0, 8'h00, 64'h0, 1, 3, 1, 0); step();
        chk("clr_rd3", rsp_data, 64'h0);
        drive(0, 0, 8'h00, 64'h0, 0, 0, 1, 0); step();

        // Randomised traffic on a narrow address range to provoke collisions
        for (int t = 0; t < 600; t++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 8'($urandom),
                  {$urandom, $urandom}, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
            step();
        end
        drive(0, 0, 8'h00, 64'h0, 0, 0, 1, 0);
        repeat (N + 4) step();

        // Reset while a response is pending
        drive(0, 0, 8'h00, 64'h0, 1, 2, 0, 0); step();
        do_reset(1);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_access_ctrl.md
# rf_access_ctrl

Front-end controller that sits directly upstream of the 32×64 register-file macro, which has one read/write port with byte write enables (port 0) and one read-only port (port 1). It arbitrates a write channel and a read request/response channel onto the macro pins, zero-initialises the array after reset or on request, and keeps reads coherent when a write to the same entry lands in the same cycle. Consumers see a valid/ready read-response stream with one-cycle latency and full throughput.

## Interface
Parameters:
- BITS, 5, address width; the array has 2**BITS entries of 64 bits.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- clr  in  1  request to re-zero the whole array.
- busy  out  1  high while the INIT state is active.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_addr  in  BITS  write entry.
- wr_be  in  8  byte enables; bit i selects bits i*8+7..i*8.
- wr_data  in  64  write data.
- rd_valid  in  1  read request.
- rd_ready  out  1  read accepted when rd_valid & rd_ready.
- rd_addr  in  BITS  read entry.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts rsp_data.
- rsp_data  out  64  read result.
- ram_en0 / ram_a0 / ram_we0 / ram_di0  out  1 / BITS / 8 / 64  macro port 0.
- ram_en1 / ram_a1  out  1 / BITS  macro port 1.
- ram_do1  in  64  macro port 1 data. The macro registers it on the edge where en1 is high and holds it otherwise.

## Operation
- FSM states:
  - INIT: the macro is written with all-ones byte enables and zero data at address init_cnt. init_cnt counts 0 to 2**BITS-1, one entry per cycle. After the last entry the FSM moves to RUN.
  - RUN: normal traffic.
- Reset: state is INIT and init_cnt is 0. Output values during reset: busy=1, wr_ready=0, rd_ready=0, rsp_valid=0, ram_en0=0, ram_en1=0, ram_we0=0.
- In RUN, wr_ready = !clr_pend. An accepted write drives ram_en0=1, ram_a0=wr_addr, ram_we0=wr_be, ram_di0=wr_data. With no write accepted, ram_en0=0.
- In RUN, rd_ready = !clr_pend & (!rsp_valid | rsp_ready). An accepted read drives ram_en1=1 and ram_a1=rd_addr.
- rsp_valid is set on the edge that accepts a read. It is cleared on the edge where rsp_valid & rsp_ready holds and no new read is accepted.
- rsp_data is combinational: for each byte i, byp_be[i] ? byp_data byte : ram_do1 byte. byp_be and byp_data are registered when the read is accepted (see Configuration). Outside that case byp_be is 0.
- Snapshot semantics: rsp_data reflects the array at the accept edge. A later write to the same entry does not alter a pending response.
- clr is sampled every edge and sets the sticky clr_pend. When clr_pend=1 and rsp_valid=0, the next edge enters INIT with init_cnt=0 and clears clr_pend. A pending response must drain first.
- clr asserted while already in INIT is ignored.

## Timing
- INIT lasts exactly 2**BITS cycles (32 by default). wr_ready and rd_ready may first rise in cycle 2**BITS after RST_N deasserts.
- Read latency is one cycle: accept at edge N gives rsp_valid=1 in cycle N+1. Back-to-back reads sustain one per cycle while rsp_ready=1.
- A write accepted at edge N is visible to any read accepted at edge N+1 or later.
- wr_ready and the clr_pend term of rd_ready depend only on registered state. There is no combinational path from clr, wr_valid or rd_valid to either ready.
- A read or write accepted in the same cycle that clr is first asserted still completes. The write is then zeroed by INIT.
- RST_N asserted mid-INIT or mid-response: immediate return to reset values, and INIT restarts from 0.

## Configuration
- RF_ACCESS_BYPASS_EN defined:
  - A read accepted in the same cycle as a write to the same address captures byp_be=wr_be and byp_data=wr_data.
  - The response therefore returns the merged new bytes.
- Not defined:
  - rd_ready is additionally forced low while wr_valid & wr_ready & (wr_addr == rd_addr). The read is accepted on a later cycle.
  - byp_be is always 0 and the merge logic is removed.
  - This is the only case where rd_ready depends combinationally on wr_* and rd_addr.

## Structure
- Package rf_access_pkg holds:
  - a state enum {INIT, RUN};
  - constants BYTES=8, WIDTH=64;
  - a byte-merge function.
- One sub-module, rf_bypass_merge: the combinational per-byte mux of byp_data/byp_be over ram_do1. It is instantiated only under RF_ACCESS_BYPASS_EN.
- The macro itself is instantiated by the parent, not inside this block.

## Test plan
- Reset release: busy=1 and ready low for 32 cycles, ram_we0=8'hFF and ram_di0=0 for addresses 0..31, then busy=0. Read addr 7 -> 64'h0.
- Write addr 3 be=8'hFF data=64'h0123456789ABCDEF, then read 3 the next cycle -> rsp_data=64'h0123456789ABCDEF one cycle after accept.
- Same-cycle write addr 5 be=8'h0F data=64'hFFFFFFFF_AAAAAAAA with read addr 5 (entry previously 64'h1111111122222222):
  - with macro -> 64'h11111111AAAAAAAA;
  - without macro -> rd_ready=0 that cycle, and the retried read returns the same value.
- rsp_ready held low 4 cycles while addr 3 is rewritten -> rsp_data stays at the old value, rd_ready=0, no ram_en1 pulses.
- clr with a response pending -> INIT begins the cycle after the response drains, lasts 32 cycles, and a subsequent read of 3 returns 0.
- RST_N asserted at init_cnt=10 -> on release INIT restarts at address 0 and lasts the full 32 cycles.
